// File: rtl/dac_ctl_seq.sv
// dac_ctl_seq: sequences DAC configuration over the 3-wire control port.
// After reset it waits POR_CYCLES, then streams the INIT_WORDS table.
// From then on it follows S/PDIF lock and rate, issuing mute / rate / unmute
// writes so that rate switches are click-free. Host writes share the port at
// lower priority than sequencer traffic.
//
// Ports:
//   clk245760    clock
//   rst          synchronous active-high reset
//   locked_i     S/PDIF receiver locked (already synchronised)
//   rate_i       one-hot rate code, valid while locked_i
//   host_req_i   host write request, held until host_ack_o
//   host_word_i  host word {addr,data}
//   host_ack_o   one-cycle pulse at the end of the host frame
//   cfg_cs_n_o   control chip select, active low
//   cfg_sck_o    control clock, idles high, DAC samples on rising edge
//   cfg_sda_o    control data, MSB first, changes on falling edge
//   mute_o       DAC muted
//   ready_o      init table complete
//   busy_o       frame in progress (CS low or inter-frame gap)
module dac_ctl_seq #(
   parameter int unsigned                  NUM_RATE     = 5,
   parameter int unsigned                  SCK_HALF     = 4,
   parameter int unsigned                  POR_CYCLES   = 4096,
   parameter int unsigned                  INIT_LEN     = 4,
   parameter logic [16*INIT_LEN-1:0]       INIT_WORDS   = 64'h7F00_0100_0200_1300,
   parameter logic [7:0]                   MUTE_ADDR    = 8'h01,
   parameter logic [7:0]                   RATE_ADDR    = 8'h02,
   parameter int unsigned                  UNMUTE_DELAY = 24576
) (
   input  logic                clk245760,
   input  logic                rst,
   input  logic                locked_i,
   input  logic [NUM_RATE-1:0] rate_i,
   input  logic                host_req_i,
   input  logic [15:0]         host_word_i,
   output logic                host_ack_o,
   output logic                cfg_cs_n_o,
   output logic                cfg_sck_o,
   output logic                cfg_sda_o,
   output logic                mute_o,
   output logic                ready_o,
   output logic                busy_o
);

   localparam int unsigned POR_W = $clog2(POR_CYCLES + 1);
   localparam int unsigned CNT_W = $clog2(2 * SCK_HALF + 1);
   localparam int unsigned IDX_W = $clog2(INIT_LEN + 1);
   localparam int unsigned DLY_W = $clog2(UNMUTE_DELAY + 1);
   localparam int unsigned PH_W  = 6;

   // Half-bit phases: 0 = lead-in after CS fall, odd = SCK low, even = SCK high.
   localparam logic [PH_W-1:0] PH_LAST = 6'd32;

   localparam logic [2:0] ST_POR   = 3'd0;
   localparam logic [2:0] ST_INIT  = 3'd1;
   localparam logic [2:0] ST_IDLE  = 3'd2;
   localparam logic [2:0] ST_SHIFT = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   // Origin of the word in flight, decides what happens at frame completion.
   localparam logic [2:0] K_INIT   = 3'd0;
   localparam logic [2:0] K_MUTE   = 3'd1;
   localparam logic [2:0] K_RATE   = 3'd2;
   localparam logic [2:0] K_UNMUTE = 3'd3;
   localparam logic [2:0] K_HOST   = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [2:0]          kind_q, kind_d;
   logic [POR_W-1:0]    por_cnt_q, por_cnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DLY_W-1:0]    dly_q, dly_d;
   logic [15:0]         shreg_q, shreg_d;
   logic                mute_pend_q, mute_pend_d;
   logic                rate_pend_q, rate_pend_d;
   logic                unmute_pend_q, unmute_pend_d;
   logic                locked_q, locked_d;
   logic [NUM_RATE-1:0] rate_q, rate_d;
   logic                cs_n_q, cs_n_d;
   logic                sck_q, sck_d;
   logic                sda_q, sda_d;
   logic                mute_q, mute_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                ack_q, ack_d;

   logic                armed_c, ev_fall_c, ev_new_c, unmute_done_c;
   logic                load_c;
   logic [15:0]         load_word_c;
   logic [2:0]          load_kind_c;

   // Index of the single set bit; anything not one-hot maps to 0.
   function automatic logic [7:0] rate_index(input logic [NUM_RATE-1:0] r);
      logic [7:0]  idx;
      int unsigned ones;
      idx  = 8'h00;
      ones = 0;
      for (int i = 0; i < int'(NUM_RATE); i++) begin
         if (r[i]) begin
            idx  = 8'(i);
            ones = ones + 1;
         end
      end
      return (ones == 1) ? idx : 8'h00;
   endfunction

   // Word i of the init table; word 0 sits in the MSBs.
   function automatic logic [15:0] init_word(input logic [IDX_W-1:0] i);
      logic [15:0] w;
      w = 16'h0000;
      for (int k = 0; k < int'(INIT_LEN); k++) begin
         if (i == IDX_W'(k)) w = INIT_WORDS[16*(INIT_LEN-1-k) +: 16];
      end
      return w;
   endfunction

   // State and datapath register
   always_ff @(posedge clk245760) begin
      if (rst) begin
         state_q       <= ST_POR;
         kind_q        <= K_INIT;
         por_cnt_q     <= '0;
         cnt_q         <= '0;
         ph_q          <= '0;
         idx_q         <= '0;
         dly_q         <= '0;
         shreg_q       <= '0;
         mute_pend_q   <= 1'b0;
         rate_pend_q   <= 1'b0;
         unmute_pend_q <= 1'b0;
         locked_q      <= 1'b0;
         rate_q        <= '0;
         cs_n_q        <= 1'b1;
         sck_q         <= 1'b1;
         sda_q         <= 1'b0;
         mute_q        <= 1'b1;
         ready_q       <= 1'b0;
         busy_q        <= 1'b0;
         ack_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         kind_q        <= kind_d;
         por_cnt_q     <= por_cnt_d;
         cnt_q         <= cnt_d;
         ph_q          <= ph_d;
         idx_q         <= idx_d;
         dly_q         <= dly_d;
         shreg_q       <= shreg_d;
         mute_pend_q   <= mute_pend_d;
         rate_pend_q   <= rate_pend_d;
         unmute_pend_q <= unmute_pend_d;
         locked_q      <= locked_d;
         rate_q        <= rate_d;
         cs_n_q        <= cs_n_d;
         sck_q         <= sck_d;
         sda_q         <= sda_d;
         mute_q        <= mute_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
         ack_q         <= ack_d;
      end
   end

   // Next-state, event tracking and word selection
   always_comb begin
      state_d       = state_q;
      kind_d        = kind_q;
      por_cnt_d     = por_cnt_q;
      cnt_d         = cnt_q;
      ph_d          = ph_q;
      idx_d         = idx_q;
      dly_d         = dly_q;
      shreg_d       = shreg_q;
      mute_pend_d   = mute_pend_q;
      rate_pend_d   = rate_pend_q;
      unmute_pend_d = unmute_pend_q;
      cs_n_d        = cs_n_q;
      sck_d         = sck_q;
      sda_d         = sda_q;
      mute_d        = mute_q;
      ready_d       = ready_q;
      busy_d        = busy_q;
      ack_d         = 1'b0;
      unmute_done_c = 1'b0;
      load_c        = 1'b0;
      load_word_c   = 16'h0000;
      load_kind_c   = K_INIT;

      // Lock/rate history is held cleared during POR so a lock already
      // present when POR ends still shows up as a rising edge.
      armed_c   = (state_q != ST_POR);
      locked_d  = armed_c ? locked_i : 1'b0;
      rate_d    = armed_c ? rate_i : '0;
      ev_fall_c = armed_c && locked_q && !locked_i;
      ev_new_c  = armed_c && locked_i && (!locked_q || (rate_i != rate_q));

      if (dly_q != '0) dly_d = dly_q - DLY_W'(1);

      case (state_q)
         ST_POR: begin
            if (por_cnt_q == POR_W'(POR_CYCLES - 1)) begin
               por_cnt_d = '0;
               idx_d     = '0;
               state_d   = ST_INIT;
            end else begin
               por_cnt_d = por_cnt_q + POR_W'(1);
            end
         end
         ST_INIT: begin
            if (idx_q == IDX_W'(INIT_LEN)) begin
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               load_c      = 1'b1;
               load_word_c = init_word(idx_q);
               load_kind_c = K_INIT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_W'(SCK_HALF - 1)) begin
               cnt_d = '0;
               if (ph_q == PH_LAST) begin
                  cs_n_d  = 1'b1;
                  sck_d   = 1'b1;
                  sda_d   = 1'b0;
                  state_d = ST_GAP;
               end else begin
                  ph_d = ph_q + PH_W'(1);
                  // Entering an odd phase is the SCK fall that presents the next bit.
                  if (!ph_q[0]) begin
                     sck_d   = 1'b0;
                     sda_d   = shreg_q[15];
                     shreg_d = {shreg_q[14:0], 1'b0};
                  end else begin
                     sck_d = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == CNT_W'(2 * SCK_HALF - 1)) begin
               cnt_d  = '0;
               busy_d = 1'b0;
               case (kind_q)
                  K_INIT: idx_d = idx_q + IDX_W'(1);
                  // Only arm the unmute if no event re-queued the sequence mid-frame.
                  K_RATE: begin
                     if (!mute_pend_q && !rate_pend_q) begin
                        unmute_pend_d = 1'b1;
                        dly_d         = DLY_W'(UNMUTE_DELAY);
                     end
                  end
                  K_UNMUTE: unmute_done_c = 1'b1;
                  K_HOST:   ack_d = 1'b1;
                  default:  ;
               endcase
               state_d = (kind_q == K_INIT) ? ST_INIT : ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase

      // Lock/rate events override whatever the frame completion decided.
      if (ev_fall_c) begin
         mute_d        = 1'b1;
         mute_pend_d   = 1'b1;
         rate_pend_d   = 1'b0;
         unmute_pend_d = 1'b0;
      end
      if (ev_new_c) begin
         mute_d        = 1'b1;
         mute_pend_d   = 1'b1;
         rate_pend_d   = 1'b1;
         unmute_pend_d = 1'b0;
      end
      if (unmute_done_c && locked_i && !mute_pend_d && !rate_pend_d && !unmute_pend_d)
         mute_d = 1'b0;

      // Flags are cleared at load, so an event during the frame re-arms them.
      if (state_q == ST_IDLE) begin
         if (mute_pend_d) begin
            load_c      = 1'b1;
            load_word_c = {MUTE_ADDR, 8'h03};
            load_kind_c = K_MUTE;
            mute_pend_d = 1'b0;
         end else if (rate_pend_d) begin
            load_c      = 1'b1;
            load_word_c = {RATE_ADDR, rate_index(rate_i)};
            load_kind_c = K_RATE;
            rate_pend_d = 1'b0;
         end else if (unmute_pend_d && (dly_q == '0)) begin
            load_c        = 1'b1;
            load_word_c   = {MUTE_ADDR, 8'h00};
            load_kind_c   = K_UNMUTE;
            unmute_pend_d = 1'b0;
         end else if (host_req_i) begin
            load_c      = 1'b1;
            load_word_c = host_word_i;
            load_kind_c = K_HOST;
         end
      end

      if (load_c) begin
         shreg_d = load_word_c;
         kind_d  = load_kind_c;
         cs_n_d  = 1'b0;
         sck_d   = 1'b1;
         cnt_d   = '0;
         ph_d    = '0;
         busy_d  = 1'b1;
         state_d = ST_SHIFT;
      end
   end

   assign cfg_cs_n_o = cs_n_q;
   assign cfg_sck_o  = sck_q;
   assign cfg_sda_o  = sda_q;
   assign mute_o     = mute_q;
   assign ready_o    = ready_q;
   assign busy_o     = busy_q;
   assign host_ack_o = ack_q;

endmodule

// File: doc/dac_ctl_seq.md
Name: dac_ctl_seq

Overview:
- Sequences configuration of the external DAC over its 3-wire control port, in the clk245760 domain, alongside the clock-forwarded MCLK.
- After reset it streams a fixed init table to the DAC.
- Afterwards it tracks S/PDIF lock and sample rate, issuing mute / rate-select / unmute writes so rate switches are click-free.
- It also arbitrates the control port with host (CSR) write requests; sequencer traffic always has priority.

Parameters:
NUM_RATE, 5, width of one-hot rate code from the S/PDIF receiver
SCK_HALF, 4, control-port SCK half-period in clk cycles (min 2)
POR_CYCLES, 4096, wait after reset before first write
INIT_LEN, 4, number of words in INIT_WORDS
INIT_WORDS, 64'h7F00_0100_0200_1300, packed 16-bit words {addr[7:0],data[7:0]}, word 0 in MSBs
MUTE_ADDR, 8'h01, mute register address (data 8'h03 mute, 8'h00 unmute)
RATE_ADDR, 8'h02, rate register address (data = index of set rate bit)
UNMUTE_DELAY, 24576, cycles between rate write and unmute write

Ports:
clk245760  in  1  clock
rst  in  1  reset, synchronous, active-high
locked_i  in  1  S/PDIF receiver locked, pre-synchronised to clk245760
rate_i  in  NUM_RATE  one-hot rate code, valid while locked_i
host_req_i  in  1  host write request, level, held until ack
host_word_i  in  16  host word {addr,data}
host_ack_o  out  1  one-cycle pulse when host word has been fully shifted
cfg_cs_n_o  out  1  DAC control chip select, active low
cfg_sck_o  out  1  DAC control clock, idles high
cfg_sda_o  out  1  DAC control data
mute_o  out  1  DAC muted (also drives soft-mute gating in datapath)
ready_o  out  1  init table complete
busy_o  out  1  a frame is in progress (CS low or inter-frame gap)

Behaviour:
- Reset values: cs_n=1, sck=1, sda=0, mute_o=1, ready_o=0, busy_o=0, host_ack_o=0. All pending flags are cleared; the rate register is cleared to 0.
- rst asserted mid-frame aborts the frame immediately; outputs return to reset values on the next edge.
- States:
  - POR: counts POR_CYCLES, then goes to INIT with idx=0.
  - INIT: loads INIT_WORDS[idx]; goes to SHIFT. Returning from GAP, idx increments; at idx==INIT_LEN, ready_o is set and the state goes to IDLE.
  - IDLE: selects the next word by priority: mute_pend > rate_pend > unmute_pend (only when the delay counter has expired) > host_req_i. It loads the word and goes to SHIFT.
  - SHIFT: drops cs_n, then idles SCK_HALF cycles. Sends 16 bits MSB first:
    - sda updates with SCK falling;
    - SCK rises SCK_HALF cycles later, where the DAC samples.
    - After bit 0's rising edge, waits SCK_HALF cycles, then cs_n=1.
  - GAP: 2*SCK_HALF cycles with cs_n high, then returns to the caller state (INIT or IDLE).
- Frame length from cs_n fall to cs_n rise: (1+2*16)*SCK_HALF cycles, i.e. 132 at default. busy_o is high from cs_n fall to GAP end.
- Event tracking (edges of locked_i; rate_q = registered rate_i) is active in every state after POR:
  - Fall of locked_i: mute_o=1 immediately (same cycle as the registered edge). Sets mute_pend; clears rate_pend and unmute_pend.
  - Rise of locked_i, or rate_i != rate_q while locked: mute_o=1; sets mute_pend and rate_pend; clears unmute_pend.
  - rate_pend data = encoded index of rate_i latched at word load. rate_i not one-hot gives index 0.
  - Completion of the rate write clears rate_pend, loads the delay counter with UNMUTE_DELAY, and sets unmute_pend.
  - A new event during the delay cancels unmute and restarts the sequence.
  - Completion of the unmute write clears mute_o, but only if locked_i is still high and no pending flag is set.
- Events arriving during INIT are queued by the flags and serviced after ready_o.
- Host writes:
  - Accepted only in IDLE with no sequencer flag eligible.
  - host_ack_o pulses one cycle at GAP end of that frame.
  - A host_req_i drop before ack is ignored once the frame has started; the frame completes.
- A frame in progress is never preempted.

Test Plan:
- Reset, locked_i=0: POR 4096 cycles, then 4 frames with words 7F00, 0100, 0200, 1300, each 132 cycles long with 8-cycle gaps → ready_o=1, mute_o=1.
- After init, locked_i rises with rate_i=5'b00100 → frames 0103, then 0202, then after 24576 cycles 0100 → mute_o falls at end of the last frame.
- While locked, rate_i changes to 5'b00010 → mute_o=1 at once; frames 0103, 0201, then delayed 0100.
- locked_i falls during the UNMUTE_DELAY wait → one 0103 frame, no unmute frame, mute_o stays 1.
- host_req_i with word 2A55 while the sequencer is idle → one frame shifting 2A55 MSB first; host_ack_o pulses once. A simultaneous lock event makes 0103 go first and the host frame second.
- rst asserted at bit 7 of a frame → next cycle cs_n=1, sck=1, mute_o=1, ready_o=0; the init sequence restarts from word 0 after POR.
